// File: rtl/axil_req_arbiter.sv
// axil_req_arbiter
// Round-robin arbiter that shares one AXI4-Lite master port between
// NUM_REQ simple request/done clients. One AXI transaction is in flight
// at a time. A six-state FSM sequences the AW/W/B or AR/R channels for
// the granted client and then returns a one-cycle done pulse.
module axil_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  // client side
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_done,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  // AXI4-Lite write address channel
  output logic [ADDR_W-1:0]           m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  // AXI4-Lite write data channel
  output logic [DATA_W-1:0]           m_axi_wdata,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  // AXI4-Lite write response channel
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  // AXI4-Lite read address channel
  output logic [ADDR_W-1:0]           m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  // AXI4-Lite read data channel
  input  logic [DATA_W-1:0]           m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int GW = $clog2(NUM_REQ);
  // Pointer starts at the last client so that client 0 wins first after reset.
  localparam logic [GW-1:0] LAST_RESET = GW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [GW-1:0]       last_q, last_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                awv_q, awv_d;
  logic                wv_q, wv_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;

  // Per-client views of the flattened address/data buses.
  logic [ADDR_W-1:0]   cl_addr  [NUM_REQ];
  logic [DATA_W-1:0]   cl_wdata [NUM_REQ];

  logic                win_found;
  logic [GW-1:0]       win_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_client
      assign cl_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign cl_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
      // Done is one-hot on the granted client during the single DONE cycle.
      assign req_done[gi] = (state_q == S_DONE) && (grant_q == GW'(gi));
    end
  endgenerate

  // Round-robin pick: first requesting client scanning from last_q+1, wrapping.
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && (i == cand) && req_valid[i]) begin
          win_found = 1'b1;
          win_idx   = GW'(i);
        end
      end
    end
  end

  // Next-state logic: grant in IDLE, then walk the AXI channels to DONE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    awv_d   = awv_q;
    wv_d    = wv_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant_d = win_idx;
          last_d  = win_idx;
          addr_d  = cl_addr[win_idx];
          wdata_d = cl_wdata[win_idx];
          if (req_we[win_idx]) begin
            // Both write valids rise together on entry to WADDR.
            awv_d   = 1'b1;
            wv_d    = 1'b1;
            state_d = S_WADDR;
          end else begin
            state_d = S_RADDR;
          end
        end
      end

      S_WADDR: begin
        // AW and W complete independently; each valid drops after its own handshake.
        if (awv_q && m_axi_awready) begin
          awv_d = 1'b0;
        end
        if (wv_q && m_axi_wready) begin
          wv_d = 1'b0;
        end
        if ((!awv_q || m_axi_awready) && (!wv_q || m_axi_wready)) begin
          state_d = S_WRESP;
        end
      end

      S_WRESP: begin
        if (m_axi_bvalid) begin
          resp_d  = m_axi_bresp;
          rdata_d = '0;
          state_d = S_DONE;
        end
      end

      S_RADDR: begin
        if (m_axi_arready) begin
          state_d = S_RDATA;
        end
      end

      S_RDATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          resp_d  = m_axi_rresp;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        awv_d   = 1'b0;
        wv_d    = 1'b0;
      end
    endcase
  end

  // State register; an asynchronous reset aborts any in-flight transaction.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RESET;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      awv_q   <= 1'b0;
      wv_q    <= 1'b0;
      rdata_q <= '0;
      resp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      awv_q   <= awv_d;
      wv_q    <= wv_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
    end
  end

  // Channel outputs come straight from registered state so they clear with reset.
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awvalid = awv_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wvalid  = wv_q;
  assign m_axi_bready  = (state_q == S_WRESP);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arvalid = (state_q == S_RADDR);
  assign m_axi_rready  = (state_q == S_RDATA);

  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign busy      = (state_q != S_IDLE);
  assign grant_id  = grant_q;

endmodule
